kmer_window: RTL and testbench

Streaming k-mer extractor that sits directly upstream of `hasher`. It accepts one 2-bit DNA base per cycle over a valid/ready handshake and maintains a sliding window of the last `KMER_SIZE` bases of the current read. It presents each complete window as a registered `kmer` array, with the same shape and ordering that `hasher` consumes, under a valid/ready handshake. It also tracks read boundaries, k-mer position within the read, and emitted/short-read statistics.

---
 rtl/kmer_window_if.sv | 31 +++
 rtl/kmer_window.sv | 99 +++++++++
 tb/tb_kmer_window.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kmer_window_if.sv
// Stream interface for kmer_window: the base input handshake plus the k-mer output
// handshake and statistics. The master side feeds bases and the slave side is the extractor.
interface kmer_window_if #(
    parameter int KMER_SIZE = 16,
    parameter int POS_W     = 16
);
    logic [1:0]       base_in;
    logic             base_valid;
    logic             base_ready;
    logic             seq_start;
    logic             seq_last;
    logic [1:0]       kmer [0:KMER_SIZE-1];
    logic             kmer_valid;
    logic             kmer_ready;
    logic [POS_W-1:0] kmer_pos;
    logic             kmer_last;
    logic [31:0]      kmer_count;
    logic [15:0]      short_read_count;

    modport master (
        output base_in, base_valid, seq_start, seq_last, kmer_ready,
        input  base_ready, kmer, kmer_valid, kmer_pos, kmer_last,
               kmer_count, short_read_count
    );

    modport slave (
        input  base_in, base_valid, seq_start, seq_last, kmer_ready,
        output base_ready, kmer, kmer_valid, kmer_pos, kmer_last,
               kmer_count, short_read_count
    );
endinterface

// File: rtl/kmer_window.sv
// Streaming k-mer extractor: shifts 2-bit bases into a KMER_SIZE window and presents
// each complete window of the current read, with read position, last flag and statistics.
module kmer_window #(
    parameter int KMER_SIZE = 16,
    parameter int POS_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    kmer_window_if.slave  bus
);
    localparam int FILL_W = $clog2(KMER_SIZE + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(KMER_SIZE);

    logic [1:0]        win [0:KMER_SIZE-1];
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic              in_read;
    logic              kv;
    logic              kl;
    logic [POS_W-1:0]  pos;
    logic [31:0]       kc;
    logic [15:0]       src;
    logic              accept;
    logic              handoff;
    logic              new_read;

    assign bus.base_ready = !kv || bus.kmer_ready;
    assign accept         = bus.base_valid && bus.base_ready;
    assign handoff        = kv && bus.kmer_ready;
    assign new_read       = bus.seq_start || !in_read;

    always_comb begin
        fill_next = fill;
        if (new_read)
            fill_next = FILL_W'(1);
        else if (fill != FULL)
            fill_next = fill + FILL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KMER_SIZE; i++)
                win[i] <= 2'b00;
            fill    <= '0;
            in_read <= 1'b0;
            kv      <= 1'b0;
            kl      <= 1'b0;
            pos     <= '0;
            kc      <= '0;
            src     <= '0;
        end else begin
            if (handoff)
                kc <= kc + 32'd1;

            if (accept) begin
                for (int i = 0; i < KMER_SIZE - 1; i++)
                    win[i] <= win[i+1];
                win[KMER_SIZE-1] <= bus.base_in;

                kv <= (fill_next == FULL);
                if (fill_next == FULL) begin
                    kl <= bus.seq_last;
                    // A window that was already full before this base continues the read.
                    if (fill == FULL && !new_read)
                        pos <= pos + POS_W'(1);
                    else
                        pos <= '0;
                end else begin
                    kl <= 1'b0;
                    if (new_read)
                        pos <= '0;
                end

                if (bus.seq_last) begin
                    in_read <= 1'b0;
                    fill    <= '0;
                    if (fill_next != FULL && src != 16'hFFFF)
                        src <= src + 16'd1;
                end else begin
                    in_read <= 1'b1;
                    fill    <= fill_next;
                end
            end else if (handoff) begin
                kv <= 1'b0;
                kl <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < KMER_SIZE; g++) begin : g_kmer
        assign bus.kmer[g] = win[g];
    end

    assign bus.kmer_valid       = kv;
    assign bus.kmer_last        = kl;
    assign bus.kmer_pos         = pos;
    assign bus.kmer_count       = kc;
    assign bus.short_read_count = src;
endmodule

// File: tb/tb_kmer_window.sv
// Directed self-checking bench for kmer_window with KMER_SIZE=16: reset, full reads,
// sliding, backpressure, short/abandoned reads and reset mid-read.
module tb_kmer_window;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    kmer_window_if #(.KMER_SIZE(16), .POS_W(16)) bus ();

    kmer_window #(.KMER_SIZE(16), .POS_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] q_kmer [$];
    logic [15:0] q_pos  [$];
    logic        q_last [$];

    function automatic logic [31:0] pack_kmer();
        logic [31:0] v;
        for (int j = 0; j < 16; j++)
            v[31-2*j -: 2] = bus.kmer[j];
        return v;
    endfunction

    // window of a read whose base i is i%4, starting at position p
    function automatic logic [31:0] ramp_kmer(input int p);
        logic [31:0] v;
        for (int j = 0; j < 16; j++)
            v[31-2*j -: 2] = 2'((p + j) % 4);
        return v;
    endfunction

    // record every k-mer that will be handed off at the coming rising edge
    always @(negedge clk) begin
        if (!rst && bus.kmer_valid && bus.kmer_ready) begin
            q_kmer.push_back(pack_kmer());
            q_pos.push_back(bus.kmer_pos);
            q_last.push_back(bus.kmer_last);
        end
    end

    task automatic clear_q();
        q_kmer.delete();
        q_pos.delete();
        q_last.delete();
    endtask

    task automatic idle(input int n);
        bus.base_valid = 1'b0;
        bus.seq_start  = 1'b0;
        bus.seq_last   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] b, input logic s, input logic l);
        logic acc;
        int   n;
        n = 0;
        bus.base_in    = b;
        bus.seq_start  = s;
        bus.seq_last   = l;
        bus.base_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = bus.base_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: base_ready stuck at %b, required 1", bus.base_ready);
                break;
            end
        end
        bus.base_valid = 1'b0;
        bus.seq_start  = 1'b0;
        bus.seq_last   = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus.kmer_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.kmer_valid); end
        total++; if (bus.kmer_count !== 32'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", bus.kmer_count); end
        rst = 1'b0;
        @(posedge clk); #1;
        bus.kmer_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            send(2'b11, i == 0, 1'b0);
        @(negedge clk);
        total++; if (bus.kmer_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", bus.kmer_valid); end
        total++; if (bus.base_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b want 0", bus.base_ready); end
        total++; if (pack_kmer() !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stall_kmer: got %h want ffffffff", pack_kmer()); end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        total++; if (bus.kmer_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", bus.kmer_valid); end
        total++; if (bus.base_ready !== 1'b1) begin bad++; $display("FAIL async_ready: got %b want 1", bus.base_ready); end
        total++; if (pack_kmer() !== 32'h0) begin bad++; $display("FAIL async_kmer: got %h want 0", pack_kmer()); end
        total++; if (bus.kmer_pos !== 16'd0) begin bad++; $display("FAIL async_pos: got %0d want 0", bus.kmer_pos); end
        total++; if (bus.kmer_last !== 1'b0) begin bad++; $display("FAIL async_last: got %b want 0", bus.kmer_last); end
        total++; if (bus.short_read_count !== 16'd0) begin bad++; $display("FAIL async_src: got %0d want 0", bus.short_read_count); end
        #1;
        rst = 1'b0;
        bus.kmer_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        clear_q();
        for (int i = 0; i < 16; i++)
            send(2'b10, i == 0, i == 15);
        idle(3);
        total++; if (q_kmer.size() !== 1) begin bad++; $display("FAIL single_n: got %0d want 1", q_kmer.size()); end
        if (q_kmer.size() > 0) begin
            total++; if (q_kmer[0] !== 32'hAAAA_AAAA) begin bad++; $display("FAIL single_kmer: got %h want aaaaaaaa", q_kmer[0]); end
            total++; if (q_pos[0] !== 16'd0) begin bad++; $display("FAIL single_pos: got %0d want 0", q_pos[0]); end
            total++; if (q_last[0] !== 1'b1) begin bad++; $display("FAIL single_last: got %b want 1", q_last[0]); end
        end
        total++; if (bus.kmer_count !== 32'd1) begin bad++; $display("FAIL single_count: got %0d want 1", bus.kmer_count); end
        total++; if (bus.kmer_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", bus.kmer_valid); end
    endtask

    task automatic test_sliding();
        logic [31:0] exp_k [5];
        exp_k[0] = 32'h00AA_AAAA;
        exp_k[1] = 32'h02AA_AAAA;
        exp_k[2] = 32'h0AAA_AAAA;
        exp_k[3] = 32'h2AAA_AAAA;
        exp_k[4] = 32'hAAAA_AAAA;
        clear_q();
        for (int i = 0; i < 20; i++)
            send((i < 4) ? 2'b00 : 2'b10, i == 0, i == 19);
        idle(3);
        total++; if (q_kmer.size() !== 5) begin bad++; $display("FAIL slide_n: got %0d want 5", q_kmer.size()); end
        for (int p = 0; p < 5 && p < q_kmer.size(); p++) begin
            total++; if (q_kmer[p] !== exp_k[p]) begin bad++; $display("FAIL slide_kmer%0d: got %h want %h", p, q_kmer[p], exp_k[p]); end
            total++; if (q_pos[p] !== 16'(p)) begin bad++; $display("FAIL slide_pos%0d: got %0d want %0d", p, q_pos[p], p); end
            total++; if (q_last[p] !== (p == 4)) begin bad++; $display("FAIL slide_last%0d: got %b want %b", p, q_last[p], p == 4); end
        end
        total++; if (bus.kmer_count !== 32'd6) begin bad++; $display("FAIL slide_count: got %0d want 6", bus.kmer_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] snap;
        clear_q();
        for (int i = 0; i < 17; i++)
            send(2'(i % 4), i == 0, 1'b0);
        bus.kmer_ready = 1'b0;
        bus.base_in    = 2'(17 % 4);
        bus.seq_start  = 1'b0;
        bus.seq_last   = 1'b0;
        bus.base_valid = 1'b1;
        @(negedge clk);
        snap = pack_kmer();
        total++; if (snap !== ramp_kmer(1)) begin bad++; $display("FAIL bp_snap: got %h want %h", snap, ramp_kmer(1)); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++; if (bus.base_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %b want 0", c, bus.base_ready); end
            total++; if (bus.kmer_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d: got %b want 1", c, bus.kmer_valid); end
            total++; if (bus.kmer_pos !== 16'd1) begin bad++; $display("FAIL bp_pos%0d: got %0d want 1", c, bus.kmer_pos); end
            total++; if (pack_kmer() !== snap) begin bad++; $display("FAIL bp_kmer%0d: got %h want %h", c, pack_kmer(), snap); end
        end
        @(posedge clk); #1;
        bus.kmer_ready = 1'b1;
        for (int i = 17; i < 20; i++)
            send(2'(i % 4), 1'b0, i == 19);
        idle(3);
        total++; if (q_kmer.size() !== 5) begin bad++; $display("FAIL bp_n: got %0d want 5", q_kmer.size()); end
        for (int p = 0; p < 5 && p < q_kmer.size(); p++) begin
            total++; if (q_kmer[p] !== ramp_kmer(p)) begin bad++; $display("FAIL bp_k%0d: got %h want %h", p, q_kmer[p], ramp_kmer(p)); end
            total++; if (q_pos[p] !== 16'(p)) begin bad++; $display("FAIL bp_p%0d: got %0d want %0d", p, q_pos[p], p); end
            total++; if (q_last[p] !== (p == 4)) begin bad++; $display("FAIL bp_l%0d: got %b want %b", p, q_last[p], p == 4); end
        end
        total++; if (bus.kmer_count !== 32'd11) begin bad++; $display("FAIL bp_count: got %0d want 11", bus.kmer_count); end
    endtask

    task automatic test_short_abandoned();
        clear_q();
        for (int i = 0; i < 10; i++)
            send(2'b01, i == 0, i == 9);
        idle(2);
        total++; if (q_kmer.size() !== 0) begin bad++; $display("FAIL short_n: got %0d want 0", q_kmer.size()); end
        total++; if (bus.short_read_count !== 16'd1) begin bad++; $display("FAIL short_src: got %0d want 1", bus.short_read_count); end
        for (int i = 0; i < 8; i++)
            send(2'b00, i == 0, 1'b0);
        for (int i = 0; i < 16; i++)
            send(2'b11, i == 0, i == 15);
        idle(3);
        total++; if (q_kmer.size() !== 1) begin bad++; $display("FAIL aband_n: got %0d want 1", q_kmer.size()); end
        if (q_kmer.size() > 0) begin
            total++; if (q_kmer[0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL aband_kmer: got %h want ffffffff", q_kmer[0]); end
            total++; if (q_pos[0] !== 16'd0) begin bad++; $display("FAIL aband_pos: got %0d want 0", q_pos[0]); end
            total++; if (q_last[0] !== 1'b1) begin bad++; $display("FAIL aband_last: got %b want 1", q_last[0]); end
        end
        total++; if (bus.short_read_count !== 16'd1) begin bad++; $display("FAIL aband_src: got %0d want 1", bus.short_read_count); end
        send(2'b10, 1'b1, 1'b1);
        idle(2);
        total++; if (bus.short_read_count !== 16'd2) begin bad++; $display("FAIL onebase_src: got %0d want 2", bus.short_read_count); end
        total++; if (bus.kmer_count !== 32'd12) begin bad++; $display("FAIL short_count: got %0d want 12", bus.kmer_count); end
    endtask

    task automatic test_reset_mid_read();
        clear_q();
        for (int i = 0; i < 8; i++)
            send(2'b10, i == 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.kmer_count !== 32'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", bus.kmer_count); end
        total++; if (bus.short_read_count !== 16'd0) begin bad++; $display("FAIL mid_src: got %0d want 0", bus.short_read_count); end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            send(2'b01, 1'b0, 1'b0);
            @(negedge clk);
            total++; if (bus.kmer_valid !== (i == 15)) begin bad++; $display("FAIL mid_valid%0d: got %b want %b", i, bus.kmer_valid, i == 15); end
            @(posedge clk); #1;
        end
        idle(2);
        total++; if (q_kmer.size() !== 1) begin bad++; $display("FAIL mid_n: got %0d want 1", q_kmer.size()); end
        if (q_kmer.size() > 0) begin
            total++; if (q_kmer[0] !== 32'h5555_5555) begin bad++; $display("FAIL mid_kmer: got %h want 55555555", q_kmer[0]); end
            total++; if (q_pos[0] !== 16'd0) begin bad++; $display("FAIL mid_pos: got %0d want 0", q_pos[0]); end
            total++; if (q_last[0] !== 1'b0) begin bad++; $display("FAIL mid_last: got %b want 0", q_last[0]); end
        end
        total++; if (bus.kmer_count !== 32'd1) begin bad++; $display("FAIL mid_count_after: got %0d want 1", bus.kmer_count); end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.base_in    = 2'b00;
        bus.base_valid = 1'b0;
        bus.seq_start  = 1'b0;
        bus.seq_last   = 1'b0;
        bus.kmer_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_sliding();
        test_backpressure();
        test_short_abandoned();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
